// File: rtl/usb_rx_deserializer.sv
// Full-speed USB receive front end: NRZI decode, SYNC detect, bit unstuffing,
// LSB-first byte assembly and EOP detection feeding rx_engine.
module usb_rx_deserializer #(
   parameter int unsigned SYNC_MIN_ZEROS = 5,
   parameter int unsigned MAX_BYTES      = 1026,
   parameter int unsigned IDLE_BITS      = 7
) (
   input  logic       clk,
   input  logic       nRST,
   input  logic       bit_strobe,
   input  logic       dp,
   input  logic       dm,
   output logic       byte_valid,
   output logic       load_data,
   output logic [7:0] data_in,
   output logic       packet_done,
   output logic       packet_abort,
   output logic       stuff_error,
   output logic       align_error
);

   localparam int unsigned ZW  = $clog2(SYNC_MIN_ZEROS + 1);
   localparam int unsigned BCW = $clog2(MAX_BYTES + 1);
   localparam int unsigned IW  = $clog2(IDLE_BITS + 1);
   localparam logic [1:0] LINE_J = 2'b10;

   typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ERROR} state_e;

   state_e           state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic [ZW-1:0]    zero_q, zero_d;
   logic [2:0]       ones_q, ones_d;
   logic [2:0]       bit_q, bit_d;
   logic [BCW-1:0]   byte_q, byte_d;
   logic [2:0]       se0_q, se0_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       data_q, data_d;
   logic             valid_d, load_d, done_d, abort_d, stuff_d, align_d;
   logic             is_j, is_k, is_se0, is_se1, dec_bit;

   assign is_j    = dp & ~dm;
   assign is_k    = ~dp & dm;
   assign is_se0  = ~dp & ~dm;
   assign is_se1  = dp & dm;
   assign dec_bit = ({dp, dm} == prev_q);

   // Next-state and output pulse logic; nothing moves without a strobe
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      zero_d  = zero_q;
      ones_d  = ones_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      se0_d   = se0_q;
      idle_d  = idle_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      load_d  = 1'b0;
      done_d  = 1'b0;
      abort_d = 1'b0;
      stuff_d = 1'b0;
      align_d = 1'b0;
      if (bit_strobe) begin
         prev_d = {dp, dm};
         idle_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (is_k) begin
                  state_d = ST_SYNC;
                  zero_d  = ZW'(1);
               end else if (is_se1) begin
                  state_d = ST_ERROR;
               end
            end
            ST_SYNC: begin
               if (is_se1) begin
                  state_d = ST_ERROR;
               end else if (is_se0) begin
                  state_d = ST_IDLE;
               end else if (!dec_bit) begin
                  if (zero_q != '1) zero_d = zero_q + ZW'(1);
               end else if (zero_q >= ZW'(SYNC_MIN_ZEROS)) begin
                  state_d = ST_DATA;
                  ones_d  = 3'd1;
                  bit_d   = 3'd0;
                  byte_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               if (is_se0) begin
                  state_d = ST_EOP;
                  se0_d   = 3'd1;
               end else if (is_se1) begin
                  state_d = ST_ERROR;
                  abort_d = 1'b1;
               end else if (ones_q == 3'd6) begin
                  // Sixth consecutive 1 must be followed by a stuffed 0
                  if (dec_bit) begin
                     state_d = ST_ERROR;
                     stuff_d = 1'b1;
                     abort_d = 1'b1;
                  end else begin
                     ones_d = 3'd0;
                  end
               end else begin
                  shreg_d = {dec_bit, shreg_q[7:1]};
                  ones_d  = dec_bit ? ones_q + 3'd1 : 3'd0;
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     if (byte_q == BCW'(MAX_BYTES)) begin
                        state_d = ST_ERROR;
                        abort_d = 1'b1;
                     end else begin
                        data_d = shreg_d;
                        load_d = 1'b1;
                        byte_d = byte_q + BCW'(1);
                     end
                  end
               end
            end
            ST_EOP: begin
               if (is_se0) begin
                  if (se0_q == 3'd3) begin
                     state_d = ST_ERROR;
                     abort_d = 1'b1;
                  end else begin
                     se0_d = se0_q + 3'd1;
                  end
               end else if (is_j) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  align_d = (bit_q != 3'd0);
               end else begin
                  state_d = ST_ERROR;
                  abort_d = 1'b1;
               end
            end
            ST_ERROR: begin
               if (is_j) begin
                  if (idle_q == IW'(IDLE_BITS - 1)) begin
                     state_d = ST_IDLE;
                     prev_d  = LINE_J;
                  end else begin
                     idle_d = idle_q + IW'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      valid_d = (state_d == ST_DATA) || (state_d == ST_EOP);
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_IDLE;
         prev_q       <= LINE_J;
         zero_q       <= '0;
         ones_q       <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         se0_q        <= '0;
         idle_q       <= '0;
         shreg_q      <= '0;
         data_q       <= '0;
         byte_valid   <= 1'b0;
         load_data    <= 1'b0;
         packet_done  <= 1'b0;
         packet_abort <= 1'b0;
         stuff_error  <= 1'b0;
         align_error  <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         zero_q       <= zero_d;
         ones_q       <= ones_d;
         bit_q        <= bit_d;
         byte_q       <= byte_d;
         se0_q        <= se0_d;
         idle_q       <= idle_d;
         shreg_q      <= shreg_d;
         data_q       <= data_d;
         byte_valid   <= valid_d;
         load_data    <= load_d;
         packet_done  <= done_d;
         packet_abort <= abort_d;
         stuff_error  <= stuff_d;
         align_error  <= align_d;
      end
   end

   assign data_in = data_q;

endmodule

// File: doc/usb_rx_deserializer.md
Name: usb_rx_deserializer

Overview:
Upstream stage of rx_engine. Takes synchronized full-speed D+/D- line samples plus a per-bit strobe from clock recovery. Performs NRZI decode, SYNC detection, bit unstuffing, LSB-first byte assembly and EOP detection. Drives rx_engine's byte_valid/load_data/data_in/packet_done, and reports line-level errors so downstream can discard the packet.

Parameters:
SYNC_MIN_ZEROS, 5, minimum decoded 0s before the terminating 1 that accept a SYNC (tolerates lost leading bits)
MAX_BYTES, 1026, maximum bytes per packet (PID + 1023 data + CRC16); exceeding this aborts the packet
IDLE_BITS, 7, consecutive J bit-times required to leave ERROR

Ports:
clk  in  1  system clock
nRST  in  1  asynchronous active-low reset
bit_strobe  in  1  one-cycle pulse per bit period; dp/dm are valid when high; pulses are at least 2 clk apart
dp  in  1  synchronized D+ sample
dm  in  1  synchronized D- sample
byte_valid  out  1  level; high while a packet body is being received (DATA and EOP states)
load_data  out  1  one-cycle pulse; data_in holds a new byte
data_in  out  8  last assembled byte; held until the next load_data
packet_done  out  1  one-cycle pulse on a valid EOP
packet_abort  out  1  one-cycle pulse when the packet is discarded due to an error
stuff_error  out  1  one-cycle pulse on a bit-stuff violation
align_error  out  1  one-cycle pulse with packet_done when EOP arrives mid-byte

Behaviour:
- Reset (async, nRST=0): state IDLE; all outputs 0; data_in=0x00. Internal state cleared: prev_line=J, ones_cnt, bit_cnt, byte_cnt, se0_cnt, idle_cnt all 0.
- Line decode: J = dp1/dm0; K = dp0/dm1; SE0 = 00; SE1 = 11.
- NRZI decode: decoded bit = 1 if the line equals prev_line, else 0. prev_line updates on every strobe.
- All state changes occur only on cycles with bit_strobe=1. Output pulses are registered and appear the cycle after the triggering strobe.
- IDLE:
  - K -> SYNC, zero_cnt=1.
  - SE1 -> ERROR.
  - Anything else: stay in IDLE.
- SYNC:
  - Decoded 0 -> zero_cnt++ (saturating).
  - Decoded 1 with zero_cnt >= SYNC_MIN_ZEROS -> DATA, ones_cnt=1, bit_cnt=0, byte_cnt=0.
  - Decoded 1 with too few zeros -> IDLE silently.
  - SE0 -> IDLE silently.
  - SE1 -> ERROR.
- DATA:
  - SE0 -> EOP, se0_cnt=1.
  - SE1 -> ERROR with packet_abort.
  - Otherwise, if ones_cnt==6: decoded 0 is dropped and ones_cnt=0; decoded 1 -> stuff_error + packet_abort, go to ERROR.
  - Otherwise the bit is shifted into bit7 of shreg (shift right); ones_cnt = bit ? ones_cnt+1 : 0; bit_cnt++ (mod 8).
  - On the 8th bit: data_in <= completed byte, load_data pulse, byte_cnt++.
  - If byte_cnt would exceed MAX_BYTES -> packet_abort, go to ERROR.
- EOP:
  - SE0 -> se0_cnt++; se0_cnt reaching 4 -> packet_abort, go to ERROR.
  - J -> packet_done pulse, go to IDLE. Also pulse align_error if bit_cnt != 0; the partial byte is discarded and gets no load_data.
  - K -> packet_abort, go to ERROR.
- ERROR:
  - byte_valid=0.
  - idle_cnt counts consecutive J strobes; any non-J clears it.
  - idle_cnt == IDLE_BITS -> IDLE with prev_line=J.
- Exclusivity: packet_done and packet_abort never assert in the same cycle. Every SYNC accepted into DATA ends with exactly one of them (unless reset intervenes).
- byte_valid rises the cycle after the SYNC-terminating strobe and falls the cycle after the EOP J strobe (or the abort strobe).
- Latency: load_data is 1 clk after the strobe carrying the byte's last data bit; a stuffed bit never produces output.
- Mid-operation reset: everything returns to reset values immediately; no packet_done or packet_abort is issued for the interrupted packet.

Test Plan:
1. Reset with line at J, 20 strobes -> all outputs remain 0; byte_valid=0; no pulses.
2. SYNC (KJKJKJKK), bytes 0xC3, 0xA5, SE0 SE0 J -> load_data x2 with data_in 0xC3 then 0xA5; single packet_done; no error pulses; byte_valid high throughout.
3. SYNC, bytes 0xFF 0x7F with stuffed 0s inserted after each run of six 1s -> data_in 0xFF then 0x7F; no stuff_error; exactly 2 load_data.
4. SYNC, seven decoded 1s with no stuffed 0 -> stuff_error and packet_abort in the same cycle; no packet_done; returns to IDLE only after 7 J strobes; a following clean packet is received correctly.
5. SYNC, one byte 0x5A, 3 extra bits, SE0 SE0 J -> one load_data (0x5A); packet_done together with align_error.
6. nRST pulsed low mid-byte in DATA -> outputs 0 immediately, no packet_done or abort; the next SYNC + 0x2D + EOP is received cleanly.
